// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and the fetch/data winner rule for the memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Only meaningful when at least one request is present.
    function automatic owner_t pick_winner(input logic if_req,
                                           input logic dm_req,
                                           input logic starved);
        if (if_req && (!dm_req || starved)) begin
            return OWN_IF;
        end
        return OWN_DM;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of fetch arbitration losses; sat forces the next contested grant to fetch.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign sat = (r_cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports, one fixed-latency access at a time.
// Grant in IDLE, strobe for MEM_LAT cycles, done pulse the cycle after; requesters wait by holding req.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               LAT_W    = $clog2(MEM_LAT) + 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    owner_t            r_owner;
    owner_t            w_winner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic [LAT_W-1:0]  r_lat;
    logic              r_run;
    logic              w_grant;
    logic              w_lat_zero;
    logic              w_starved;
    logic              w_starve_inc;
    logic              w_starve_clr;
    logic              w_capture;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_starve_inc),
        .clr   (w_starve_clr),
        .sat   (w_starved)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_winner    = pick_winner(if_req, dm_req, w_starved);
        case (r_state)
            IDLE: begin
                // r_run holds off grants until the first edge after reset release.
                if (r_run && (if_req || dm_req)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (w_lat_zero) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_lat_zero   = (r_lat == '0);
    assign w_capture    = (r_state == ACCESS) && w_lat_zero && !r_we;
    assign w_starve_inc = w_grant && if_req && (w_winner == OWN_DM);
    assign w_starve_clr = w_grant && (w_winner == OWN_IF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_owner    <= OWN_IF;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_lat      <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_grant) begin
                r_owner <= w_winner;
                r_lat   <= LAT_INIT;
                if (w_winner == OWN_DM) begin
                    r_we    <= dm_we;
                    r_addr  <= dm_addr;
                    r_wdata <= dm_wdata;
                end else begin
                    r_we    <= 1'b0;
                    r_addr  <= if_addr;
                end
            end else if ((r_state == ACCESS) && !w_lat_zero) begin
                r_lat <= r_lat - LAT_W'(1);
            end
            if (w_capture) begin
                if (r_owner == OWN_IF) begin
                    r_if_rdata <= mem_rdata;
                end else begin
                    r_dm_rdata <= mem_rdata;
                end
            end
        end
    end

    assign if_gnt    = w_grant && (w_winner == OWN_IF);
    assign dm_gnt    = w_grant && (w_winner == OWN_DM);
    assign if_done   = (r_state == DONE) && (r_owner == OWN_IF);
    assign dm_done   = (r_state == DONE) && (r_owner == OWN_DM);
    assign mem_rd    = (r_state == ACCESS) && !r_we;
    assign mem_wr    = (r_state == ACCESS) && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: MEM_LAT=2 and MEM_LAT=1 instances on shared stimulus,
// checked each cycle against a time-since-grant model plus directed literal expectations.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int SMAX = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       if_req, dm_req, dm_we;
    logic [7:0] if_addr, dm_addr;
    logic [31:0] dm_wdata;

    logic [1:0]       if_gnt_v, if_done_v, dm_gnt_v, dm_done_v, mem_rd_v, mem_wr_v;
    logic [1:0][31:0] if_rdata_v, dm_rdata_v, mem_wdata_v, mem_rdata_v;
    logic [1:0][7:0]  mem_addr_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rdfn(input logic [7:0] a);
        if (a == 8'h04) return 32'h8C220000;
        return {~a, a, 16'h1234};
    endfunction

    assign mem_rdata_v[0] = rdfn(mem_addr_v[0]);
    assign mem_rdata_v[1] = rdfn(mem_addr_v[1]);

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(SMAX)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_v[0]),
        .if_done(if_done_v[0]), .if_rdata(if_rdata_v[0]),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt_v[0]), .dm_done(dm_done_v[0]), .dm_rdata(dm_rdata_v[0]),
        .mem_rd(mem_rd_v[0]), .mem_wr(mem_wr_v[0]), .mem_addr(mem_addr_v[0]),
        .mem_wdata(mem_wdata_v[0]), .mem_rdata(mem_rdata_v[0])
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_v[1]),
        .if_done(if_done_v[1]), .if_rdata(if_rdata_v[1]),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt_v[1]), .dm_done(dm_done_v[1]), .dm_rdata(dm_rdata_v[1]),
        .mem_rd(mem_rd_v[1]), .mem_wr(mem_wr_v[1]), .mem_addr(mem_addr_v[1]),
        .mem_wdata(mem_wdata_v[1]), .mem_rdata(mem_rdata_v[1])
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: each instance is either free (k==0) or k cycles past its grant.
    int          lat_of [2] = '{2, 1};
    int          m_k    [2];
    bit          m_run  [2];
    int          m_starve [2];
    owner_t      m_own  [2];
    bit          m_we   [2];
    logic [7:0]  m_addr [2];
    logic [31:0] m_wdata[2];
    logic [31:0] m_ifr  [2];
    logic [31:0] m_dmr  [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_k[i] = 0; m_run[i] = 0; m_starve[i] = 0; m_own[i] = OWN_IF; m_we[i] = 0;
            m_addr[i] = '0; m_wdata[i] = '0; m_ifr[i] = '0; m_dmr[i] = '0;
        end
    end

    always @(negedge clk) begin
        owner_t w;
        logic e_ifg, e_dmg, e_rd, e_wr, e_ifd, e_dmd;
        int nk;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                chk($sformatf("rst_if_gnt[%0d]", i), if_gnt_v[i], 0);
                chk($sformatf("rst_dm_gnt[%0d]", i), dm_gnt_v[i], 0);
                chk($sformatf("rst_if_done[%0d]", i), if_done_v[i], 0);
                chk($sformatf("rst_dm_done[%0d]", i), dm_done_v[i], 0);
                chk($sformatf("rst_mem_rd[%0d]", i), mem_rd_v[i], 0);
                chk($sformatf("rst_mem_wr[%0d]", i), mem_wr_v[i], 0);
                chk($sformatf("rst_mem_addr[%0d]", i), mem_addr_v[i], 0);
                chk($sformatf("rst_mem_wdata[%0d]", i), mem_wdata_v[i], 0);
                chk($sformatf("rst_if_rdata[%0d]", i), if_rdata_v[i], 0);
                chk($sformatf("rst_dm_rdata[%0d]", i), dm_rdata_v[i], 0);
                m_k[i] = 0; m_run[i] = 0; m_starve[i] = 0; m_we[i] = 0;
                m_addr[i] = '0; m_wdata[i] = '0; m_ifr[i] = '0; m_dmr[i] = '0;
            end else begin
                e_ifg = 0; e_dmg = 0; e_rd = 0; e_wr = 0; e_ifd = 0; e_dmd = 0;
                nk = 0;
                if (m_k[i] == 0) begin
                    if (m_run[i] && (if_req || dm_req)) begin
                        w = pick_winner(if_req, dm_req, m_starve[i] == SMAX);
                        m_own[i] = w;
                        nk = 1;
                        if (w == OWN_IF) begin
                            e_ifg = 1; m_we[i] = 0; m_addr[i] = if_addr; m_starve[i] = 0;
                        end else begin
                            e_dmg = 1; m_we[i] = dm_we; m_addr[i] = dm_addr; m_wdata[i] = dm_wdata;
                            if (if_req && m_starve[i] < SMAX) m_starve[i]++;
                        end
                    end
                end else if (m_k[i] <= lat_of[i]) begin
                    e_rd = !m_we[i];
                    e_wr = m_we[i];
                    if (m_k[i] == lat_of[i] && !m_we[i]) begin
                        if (m_own[i] == OWN_IF) m_ifr[i] = rdfn(m_addr[i]);
                        else                    m_dmr[i] = rdfn(m_addr[i]);
                    end
                    nk = m_k[i] + 1;
                end else begin
                    e_ifd = (m_own[i] == OWN_IF);
                    e_dmd = (m_own[i] == OWN_DM);
                end
                chk($sformatf("if_gnt[%0d]", i), if_gnt_v[i], e_ifg);
                chk($sformatf("dm_gnt[%0d]", i), dm_gnt_v[i], e_dmg);
                chk($sformatf("mem_rd[%0d]", i), mem_rd_v[i], e_rd);
                chk($sformatf("mem_wr[%0d]", i), mem_wr_v[i], e_wr);
                chk($sformatf("if_done[%0d]", i), if_done_v[i], e_ifd);
                chk($sformatf("dm_done[%0d]", i), dm_done_v[i], e_dmd);
                if (e_rd || e_wr) chk($sformatf("mem_addr[%0d]", i), mem_addr_v[i], m_addr[i]);
                if (e_wr) chk($sformatf("mem_wdata[%0d]", i), mem_wdata_v[i], m_wdata[i]);
                if (e_ifd || e_dmd) begin
                    chk($sformatf("if_rdata[%0d]", i), if_rdata_v[i], m_ifr[i]);
                    chk($sformatf("dm_rdata[%0d]", i), dm_rdata_v[i], m_dmr[i]);
                end
                m_k[i]   = nk;
                m_run[i] = 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        if_req = 0; dm_req = 0;
        repeat (n) cyc();
    endtask

    initial begin
        rst_n = 0; if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        neg();
        chk("reset_mem_addr", mem_addr_v[0], 32'h0);
        chk("reset_dm_rdata", dm_rdata_v[0], 32'h0);
        cyc(); cyc();
        rst_n = 1;
        cyc();

        // Single fetch: both instances grant in the same cycle.
        if_req = 1; if_addr = 8'h04;
        neg(); chk("fetch_gnt", if_gnt_v[0], 1); chk("fetch_gnt_lat1", if_gnt_v[1], 1);
        cyc(); if_req = 0;
        neg(); chk("fetch_rd_t1", mem_rd_v[0], 1); chk("fetch_addr", mem_addr_v[0], 32'h04);
        chk("fetch_rd_lat1_t1", mem_rd_v[1], 1);
        cyc();
        neg(); chk("fetch_rd_t2", mem_rd_v[0], 1); chk("fetch_done_lat1", if_done_v[1], 1);
        chk("fetch_rdata_lat1", if_rdata_v[1], 32'h8C220000); chk("fetch_rd_lat1_t2", mem_rd_v[1], 0);
        cyc();
        neg(); chk("fetch_done", if_done_v[0], 1); chk("fetch_rdata", if_rdata_v[0], 32'h8C220000);
        chk("fetch_rd_t3", mem_rd_v[0], 0);
        cyc();

        // Data write.
        dm_req = 1; dm_we = 1; dm_addr = 8'h10; dm_wdata = 32'hDEADBEEF;
        neg(); chk("wr_gnt", dm_gnt_v[0], 1);
        cyc(); dm_req = 0;
        neg(); chk("wr_strobe", mem_wr_v[0], 1); chk("wr_addr", mem_addr_v[0], 32'h10);
        chk("wr_data", mem_wdata_v[0], 32'hDEADBEEF);
        cyc();
        neg(); chk("wr_strobe_t2", mem_wr_v[0], 1);
        cyc();
        neg(); chk("wr_done", dm_done_v[0], 1); chk("wr_rdata_kept", dm_rdata_v[0], 32'h0);
        cyc();

        // Data read, then a write that must leave dm_rdata alone.
        dm_req = 1; dm_we = 0; dm_addr = 8'h20;
        cyc(); dm_req = 0;
        cyc(); cyc();
        neg(); chk("rd_done", dm_done_v[0], 1); chk("rd_rdata", dm_rdata_v[0], 32'hDF201234);
        cyc();
        dm_req = 1; dm_we = 1; dm_addr = 8'h24; dm_wdata = 32'h0BADF00D;
        cyc(); dm_req = 0;
        cyc(); cyc();
        neg(); chk("wr2_done", dm_done_v[0], 1); chk("wr2_rdata_kept", dm_rdata_v[0], 32'hDF201234);
        idle(4);

        // Back-to-back: held dm_req regranted exactly 4 cycles later.
        dm_req = 1; dm_we = 0; dm_addr = 8'h30;
        for (int k = 0; k <= 4; k++) begin
            neg();
            chk($sformatf("b2b_dm_gnt_k%0d", k), dm_gnt_v[0], (k == 0 || k == 4) ? 1 : 0);
            cyc();
        end
        idle(6);

        // Contention: dm x4 then if, repeating.
        if_req = 1; if_addr = 8'h40; dm_req = 1; dm_we = 0; dm_addr = 8'h50;
        for (int k = 0; k <= 24; k++) begin
            neg();
            chk($sformatf("cont_dm_gnt_k%0d", k), dm_gnt_v[0], ((k % 4 == 0) && k != 16) ? 1 : 0);
            chk($sformatf("cont_if_gnt_k%0d", k), if_gnt_v[0], (k == 16) ? 1 : 0);
            cyc();
        end
        idle(6);

        // Reset in the first write-strobe cycle.
        dm_req = 1; dm_we = 1; dm_addr = 8'h60; dm_wdata = 32'h12345678;
        neg(); chk("mid_gnt", dm_gnt_v[0], 1);
        cyc(); dm_req = 0;
        chk("mid_wr_before", mem_wr_v[0], 1);
        #1 rst_n = 0;
        #1 chk("mid_wr_dropped", mem_wr_v[0], 0); chk("mid_wr_dropped_lat1", mem_wr_v[1], 0);
        cyc(); cyc();
        rst_n = 1;
        cyc();
        dm_req = 1; dm_we = 0; dm_addr = 8'h04;
        neg(); chk("post_rst_gnt", dm_gnt_v[0], 1);
        cyc(); dm_req = 0;
        cyc(); cyc();
        neg(); chk("post_rst_done", dm_done_v[0], 1); chk("post_rst_rdata", dm_rdata_v[0], 32'h8C220000);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
